// File: rtl/if_id_buffer.sv
// if_id_buffer: fetch-to-decode decoupling FIFO carrying {pc, instr} pairs.
// Optional zero-latency bypass when empty: define IFID_BYPASS_EN.
module if_id_buffer #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_pc,
    input  logic [DATA_W-1:0] in_instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_pc,
    output logic [DATA_W-1:0] out_pc4,
    output logic [DATA_W-1:0] out_instr,
    output logic [CNT_W-1:0]  count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] pc_mem_q    [DEPTH];
    logic [DATA_W-1:0] instr_mem_q [DEPTH];

    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic              empty;
    logic              byp;
    logic              byp_take;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] head_pc;
    logic [DATA_W-1:0] head_instr;

    assign empty = (count_q == '0);

`ifdef IFID_BYPASS_EN
    // An empty buffer forwards the fetch slot straight to decode.
    assign byp = rst & empty & in_valid & ~flush;
`else
    assign byp = 1'b0;
`endif

    assign in_ready  = rst & (count_q < CNT_W'(DEPTH));
    assign out_valid = ~empty | byp;
    assign count     = count_q;

    // A bypassed entry that decode takes is never written.
    assign byp_take = byp & out_ready;
    assign push     = in_valid & in_ready & ~flush & ~byp_take;
    assign pop      = out_valid & out_ready & ~flush & ~byp_take;

    assign head_pc    = byp ? in_pc    : pc_mem_q[rd_ptr_q];
    assign head_instr = byp ? in_instr : instr_mem_q[rd_ptr_q];

    // Empty slots read as a NOP bubble at pc 0.
    always_comb begin
        out_pc    = '0;
        out_instr = '0;
        if (out_valid) begin
            out_pc    = head_pc;
            out_instr = head_instr;
        end
        out_pc4 = out_pc + DATA_W'(4);
    end

    // Pointer and occupancy update; flush wins over push and pop.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Control state register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem_q[wr_ptr_q]    <= in_pc;
            instr_mem_q[wr_ptr_q] <= in_instr;
        end
    end

endmodule
